// File: rtl/cmp_pkg.sv
// Shared types for the byte-serial magnitude comparator.
//   state_t      : sequencer states IDLE / RUN / DONE
//   res_t        : one-hot verdict {gt, eq, lt}
//   RES_*        : verdict constants (RES_NONE = no verdict, used while idle)
//   norm_cascade : folds an arbitrary cascade-in triple into a one-hot verdict
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } res_t;

    localparam res_t RES_GT   = 3'b100;
    localparam res_t RES_EQ   = 3'b010;
    localparam res_t RES_LT   = 3'b001;
    localparam res_t RES_NONE = 3'b000;

    // Priority gt > lt > eq; anything without gt or lt (including all-zero) is EQ.
    function automatic res_t norm_cascade(input logic g, input logic e, input logic l);
        res_t r;
        casez ({g, l, e})
            3'b1??:  r = RES_GT;
            3'b01?:  r = RES_LT;
            default: r = RES_EQ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cmp8_cascade.sv
// Combinational 8-bit cascadable magnitude-comparator slice.
//   a, b       : byte operands (unsigned)
//   g, e, l    : cascade-in verdict from the less significant bytes
//   gt, eq, lt : cascade-out verdict; this byte decides unless a == b
module cmp8_cascade (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       g,
    input  logic       e,
    input  logic       l,
    output logic       gt,
    output logic       eq,
    output logic       lt
);

    always_comb begin
        if (a > b) begin
            {gt, eq, lt} = 3'b100;
        end else if (a < b) begin
            {gt, eq, lt} = 3'b001;
        end else begin
            {gt, eq, lt} = {g, e, l};
        end
    end

endmodule

// File: rtl/cmp_seq_ctrl.sv
// Byte-serial wide-operand comparator sequencer. One cmp8_cascade slice is
// reused NBYTES times, LSB byte first, with each byte verdict fed back as the
// next cascade input.
//   clk, rst_n               : clock, asynchronous active-low reset
//   start_valid/start_ready  : request handshake; op_a, op_b, signed_i and
//                              cin_gt/eq/lt are sampled on accept
//   res_valid/res_ready      : verdict handshake; res_gt/eq/lt one-hot while valid
//   busy                     : high while a request is in RUN or DONE
module cmp_seq_ctrl
    import cmp_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                signed_i,
    input  logic                cin_gt,
    input  logic                cin_eq,
    input  logic                cin_lt,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_gt,
    output logic                res_eq,
    output logic                res_lt,
    output logic                busy
);

    localparam int              W    = 8 * NBYTES;
    localparam int              IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBYTES - 1);

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic [W-1:0]    a_q, b_q;
    logic            sgn_q;
    res_t            cas_q, cas_d;
    res_t            res_q;
    logic            res_valid_q;
    logic            start_ready_q;

    logic [7:0]      a_byte, b_byte;
    logic            accept;

    assign accept = start_valid & start_ready_q;

    // Byte select. For a signed compare only the top byte carries the sign;
    // flipping its bit 7 maps two's-complement order onto unsigned order.
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_byte = a_q[8*i +: 8];
                b_byte = b_q[8*i +: 8];
            end
        end
        if (sgn_q && (idx_q == LAST)) begin
            a_byte[7] = ~a_byte[7];
            b_byte[7] = ~b_byte[7];
        end
    end

    cmp8_cascade u_slice (
        .a  (a_byte),
        .b  (b_byte),
        .g  (cas_q.gt),
        .e  (cas_q.eq),
        .l  (cas_q.lt),
        .gt (cas_d.gt),
        .eq (cas_d.eq),
        .lt (cas_d.lt)
    );

    // Operands are only meaningful between accept and DONE, so they need no reset.
    always_ff @(posedge clk) begin
        if ((state_q == IDLE) && accept) begin
            a_q <= op_a;
            b_q <= op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            sgn_q         <= 1'b0;
            cas_q         <= RES_EQ;
            res_q         <= RES_NONE;
            res_valid_q   <= 1'b0;
            start_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready rises on the first edge after reset release.
                    start_ready_q <= 1'b1;
                    if (accept) begin
                        sgn_q         <= signed_i;
                        idx_q         <= '0;
                        cas_q         <= norm_cascade(cin_gt, cin_eq, cin_lt);
                        start_ready_q <= 1'b0;
                        state_q       <= RUN;
                    end
                end
                RUN: begin
                    cas_q <= cas_d;
                    if (idx_q == LAST) begin
                        res_q       <= cas_d;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q   <= 1'b0;
                        res_q         <= RES_NONE;
                        start_ready_q <= 1'b1;
                        state_q       <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign start_ready = start_ready_q;
    assign res_valid   = res_valid_q;
    assign res_gt      = res_q.gt;
    assign res_eq      = res_q.eq;
    assign res_lt      = res_q.lt;
    assign busy        = (state_q != IDLE);

endmodule
